io_device_hub: RTL and testbench
================================

IO_DEVICE_HUB -- requirements
Module: io_device_hub

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- DATA_W, 32, data width of all value buses.
- NUM_DEV, 8, number of addressable device ids (0..NUM_DEV-1); ids >= NUM_DEV are invalid.
- PROM_ID, 2, device id served by the external ROM.
- CONSDEV_ID, 3, console loopback device id.
- WFIFO_DEPTH, 4, write FIFO entries toward IPC (power of 2, >= 2).
- TIMEOUT, 255, maximum cycles to wait for an IPC read.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on posedge.
- reset, in, 1, synchronous, active-high.
- req_valid, in, 1, request present.
- req_ready, out, 1, request accepted when req_valid && req_ready.
- is_write, in, 1, 1 = write, 0 = read.
- device_id, in, 8, target device.
- value_in, in, DATA_W, write data, or PROM address (low 16 bits) on reads.
- resp_valid, out, 1, one-cycle pulse carrying read data.
- value_out, out, DATA_W, read data; held until the next response.
- resp_err, out, 1, qualified by resp_valid: timeout, invalid id or PROM write.
- rom_addr, out, 16, PROM address, registered.
- rom_data, in, DATA_W, ROM data valid 1 cycle after rom_addr is issued.
- ipc_out_valid, ipc_out_ready, out/in, 1, write FIFO head handshake.
- ipc_out_id, out, 8, device id of the FIFO head.
- ipc_out_data, out, DATA_W, data of the FIFO head.
- ipc_in_req, out, 1, IPC read request; held until ipc_in_valid or timeout.
- ipc_in_id, out, 8, device id of the IPC read.
- ipc_in_valid, in, 1, IPC read data present.
- ipc_in_data, in, DATA_W, IPC read data.

Function
REQ-003 SHALL implement FSM states IDLE, ROM_WAIT, ROM_RESP, DRAIN, IPC_WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-004 In IDLE, req_ready SHALL also require a non-full write FIFO.
REQ-005 Accepted IPC write (id valid, not PROM_ID, not CONSDEV_ID): push {device_id, value_in} to the FIFO; no response; FSM stays IDLE.
REQ-006 Accepted write to CONSDEV_ID SHALL update the console register and emit no response.
REQ-007 Accepted write to PROM_ID or an invalid id SHALL not modify state and SHALL produce the RESP state with resp_err=1, value_out=0.
REQ-008 Read of PROM_ID: rom_addr<=value_in[15:0] -> ROM_WAIT -> ROM_RESP, capturing rom_data -> RESP; total latency from acceptance to resp_valid is 3 cycles.
REQ-009 Read of CONSDEV_ID SHALL return the console register (reset 0) via RESP; latency 1 cycle.
REQ-010 Read of an IPC id: go to DRAIN until the FIFO is empty (read-after-write ordering), then IPC_WAIT asserting ipc_in_req, with ipc_in_id = the captured id.
REQ-011 In IPC_WAIT, ipc_in_valid SHALL capture ipc_in_data into RESP with resp_err=0; the wait counter SHALL clear on entry.
REQ-012 If the counter reaches TIMEOUT without ipc_in_valid: RESP with value_out=0, resp_err=1; ipc_in_valid arriving in that same cycle SHALL win.
REQ-013 Read of an invalid id SHALL go to RESP with resp_err=1, value_out=0, 1-cycle latency.
REQ-014 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE.
REQ-015 FIFO: push on acceptance, pop on ipc_out_valid && ipc_out_ready; a simultaneous push and pop when full SHALL be impossible (req_ready=0); a simultaneous push and pop otherwise SHALL keep count; pointers wrap modulo WFIFO_DEPTH.
REQ-016 FIFO drain SHALL proceed independently of FSM state.

Reset
REQ-017 On reset: FSM=IDLE, FIFO empty, console=0, counter=0; all outputs 0 except req_ready=1; an in-flight read is abandoned with no response.
REQ-018 Reset asserted with ipc_in_req high SHALL deassert ipc_in_req the following cycle.

Verification
REQ-019 Scenarios:
- Write id 5 data 0xA5A5A5A5, ipc_out_ready=1 -> ipc_out_valid next cycle with id 5 and that data, no resp_valid.
- Five IPC writes with ipc_out_ready=0, depth 4 -> four accepted, req_ready=0 on the fifth until one pop.
- PROM read with address 0x0010 -> rom_addr=0x0010, and after 3 cycles resp_valid with value_out = ROM[0x10].
- Console write 0x1234, then console read -> value_out 0x1234, resp_err 0.
- IPC read of id 6 with two writes pending -> ipc_in_req only after both pops; ipc_in_valid withheld -> response after TIMEOUT cycles with err=1, value 0.
- Reset during IPC_WAIT -> next cycle req_ready=1, ipc_in_req=0, no resp_valid.

Source files
------------

// File: rtl/io_device_hub.sv
// Request hub routing reads/writes to an external ROM, a console loopback register,
// or an IPC channel (buffered write FIFO toward IPC, timed read request from IPC).
module io_device_hub #(
  parameter int DATA_W      = 32,
  parameter int NUM_DEV     = 8,
  parameter int PROM_ID     = 2,
  parameter int CONSDEV_ID  = 3,
  parameter int WFIFO_DEPTH = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_write,
  input  logic [7:0]        device_id,
  input  logic [DATA_W-1:0] value_in,
  output logic              resp_valid,
  output logic [DATA_W-1:0] value_out,
  output logic              resp_err,
  output logic [15:0]       rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ipc_out_valid,
  input  logic              ipc_out_ready,
  output logic [7:0]        ipc_out_id,
  output logic [DATA_W-1:0] ipc_out_data,
  output logic              ipc_in_req,
  output logic [7:0]        ipc_in_id,
  input  logic              ipc_in_valid,
  input  logic [DATA_W-1:0] ipc_in_data,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // the source holds valid and its payload steady until that edge, and ready never
  // depends combinationally on valid.

  localparam int PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(WFIFO_DEPTH + 1);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ROM_WAIT = 3'd1,
    ROM_RESP = 3'd2,
    DRAIN    = 3'd3,
    IPC_WAIT = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   value_out_q, value_out_d;
  logic                resp_err_q, resp_err_d;
  logic [15:0]         rom_addr_q, rom_addr_d;
  logic                ipc_in_req_q, ipc_in_req_d;
  logic [7:0]          ipc_in_id_q, ipc_in_id_d;
  logic [DATA_W-1:0]   cons_q, cons_d;
  logic [TMO_W-1:0]    wcnt_q, wcnt_d;
  logic [7:0]          mem_id_q [WFIFO_DEPTH];
  logic [7:0]          mem_id_d [WFIFO_DEPTH];
  logic [DATA_W-1:0]   mem_data_q [WFIFO_DEPTH];
  logic [DATA_W-1:0]   mem_data_d [WFIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic             accept;
  logic             pop;
  logic             push;
  logic             id_valid;
  logic             id_prom;
  logic             id_cons;
  logic [TMO_W-1:0] wcnt_inc;

  assign accept   = req_valid && req_ready_q;
  assign pop      = (count_q != '0) && ipc_out_ready;
  assign id_valid = ({1'b0, device_id} < 9'(NUM_DEV));
  assign id_prom  = (device_id == 8'(PROM_ID));
  assign id_cons  = (device_id == 8'(CONSDEV_ID));
  assign wcnt_inc = wcnt_q + TMO_W'(1);

  always_comb begin
    state_d     = state_q;
    value_out_d = value_out_q;
    resp_err_d  = resp_err_q;
    rom_addr_d  = rom_addr_q;
    ipc_in_id_d = ipc_in_id_q;
    cons_d      = cons_q;
    wcnt_d      = wcnt_q;
    mem_id_d    = mem_id_q;
    mem_data_d  = mem_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    push        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!id_valid || (is_write && id_prom)) begin
            state_d     = RESP;
            value_out_d = '0;
            resp_err_d  = 1'b1;
          end else if (is_write) begin
            if (id_cons) cons_d = value_in;
            else         push   = 1'b1;
          end else if (id_prom) begin
            rom_addr_d = value_in[15:0];
            state_d    = ROM_WAIT;
          end else if (id_cons) begin
            state_d     = RESP;
            value_out_d = cons_q;
            resp_err_d  = 1'b0;
          end else begin
            ipc_in_id_d = device_id;
            state_d     = DRAIN;
          end
        end
      end
      ROM_WAIT: state_d = ROM_RESP;
      ROM_RESP: begin
        state_d     = RESP;
        value_out_d = rom_data;
        resp_err_d  = 1'b0;
      end
      // Pending writes must reach IPC before the read is issued.
      DRAIN: begin
        if (count_q == '0) begin
          state_d = IPC_WAIT;
          wcnt_d  = '0;
        end
      end
      IPC_WAIT: begin
        if (ipc_in_valid) begin
          state_d     = RESP;
          value_out_d = ipc_in_data;
          resp_err_d  = 1'b0;
        end else if (wcnt_inc == TMO_W'(TIMEOUT)) begin
          state_d     = RESP;
          value_out_d = '0;
          resp_err_d  = 1'b1;
          wcnt_d      = wcnt_inc;
        end else begin
          wcnt_d = wcnt_inc;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_id_d[wr_ptr_q]   = device_id;
      mem_data_d[wr_ptr_q] = value_in;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Outputs are registered from the next state so they line up with it.
    resp_valid_d = (state_d == RESP);
    ipc_in_req_d = (state_d == IPC_WAIT);
    req_ready_d  = (state_d == IDLE) && (count_d != CNT_W'(WFIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      value_out_q  <= '0;
      resp_err_q   <= 1'b0;
      rom_addr_q   <= '0;
      ipc_in_req_q <= 1'b0;
      ipc_in_id_q  <= '0;
      cons_q       <= '0;
      wcnt_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < WFIFO_DEPTH; i++) begin
        mem_id_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      value_out_q  <= value_out_d;
      resp_err_q   <= resp_err_d;
      rom_addr_q   <= rom_addr_d;
      ipc_in_req_q <= ipc_in_req_d;
      ipc_in_id_q  <= ipc_in_id_d;
      cons_q       <= cons_d;
      wcnt_q       <= wcnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_id_q     <= mem_id_d;
      mem_data_q   <= mem_data_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign value_out     = value_out_q;
  assign resp_err      = resp_err_q;
  assign rom_addr      = rom_addr_q;
  assign ipc_out_valid = (count_q != '0);
  assign ipc_out_id    = mem_id_q[rd_ptr_q];
  assign ipc_out_data  = mem_data_q[rd_ptr_q];
  assign ipc_in_req    = ipc_in_req_q;
  assign ipc_in_id     = ipc_in_id_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_io_device_hub.sv
// Bench for io_device_hub: vector table for single requests, hand sequences for FIFO,
// drain/timeout and reset corners; responses and FIFO pops checked against queues.
module tb_io_device_hub;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT     = 255;
  localparam int WFIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, is_write;
  logic [7:0]        device_id;
  logic [DATA_W-1:0] value_in;
  logic              resp_valid, resp_err;
  logic [DATA_W-1:0] value_out;
  logic [15:0]       rom_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic              ipc_out_valid, ipc_out_ready;
  logic [7:0]        ipc_out_id;
  logic [DATA_W-1:0] ipc_out_data;
  logic              ipc_in_req, ipc_in_valid;
  logic [7:0]        ipc_in_id;
  logic [DATA_W-1:0] ipc_in_data;
  logic [2:0]        dbg_state;

  io_device_hub #(.DATA_W(DATA_W), .WFIFO_DEPTH(WFIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .is_write(is_write), .device_id(device_id), .value_in(value_in),
    .resp_valid(resp_valid), .value_out(value_out), .resp_err(resp_err),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ipc_out_valid(ipc_out_valid), .ipc_out_ready(ipc_out_ready),
    .ipc_out_id(ipc_out_id), .ipc_out_data(ipc_out_data),
    .ipc_in_req(ipc_in_req), .ipc_in_id(ipc_in_id),
    .ipc_in_valid(ipc_in_valid), .ipc_in_data(ipc_in_data), .dbg_state(dbg_state)
  );

  // ---------------- clock / ROM model ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [15:0] a);
    return {a ^ 16'hBEEF, a};
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [DATA_W:0]          exp_q[$];
  logic [8+DATA_W-1:0]      fifo_exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got err=%0b value=%h expected no response", resp_err, value_out);
        end else begin
          chk("resp", 64'({resp_err, value_out}), 64'(exp_q.pop_front()));
        end
      end
      if (ipc_out_valid && ipc_out_ready) begin
        if (fifo_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pop: got id=%h data=%h expected no entry", ipc_out_id, ipc_out_data);
        end else begin
          chk("fifo_pop", 64'({ipc_out_id, ipc_out_data}), 64'(fifo_exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic w, input logic [7:0] id, input logic [DATA_W-1:0] v);
    int n = 0;
    req_valid = 1'b1; is_write = w; device_id = id; value_in = v;
    while (!req_ready && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 400 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < TIMEOUT + 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no resp_valid expected one within %0d cycles", TIMEOUT + 20);
    end
  endtask

  task automatic wait_ipc_req();
    int n = 0;
    while (!ipc_in_req && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("ipc_in_req_rise", 64'(ipc_in_req), 64'(1));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        w;
    logic [7:0]  id;
    logic [31:0] val;
    logic        exp_resp;
    logic        exp_err;
    logic [31:0] exp_val;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    reset = 1'b1; req_valid = 1'b0; is_write = 1'b0; device_id = '0; value_in = '0;
    ipc_out_ready = 1'b0; ipc_in_valid = 1'b0; ipc_in_data = '0;

    vecs[0]  = '{1'b0, 8'd3,   32'd0,          1'b1, 1'b0, 32'd0,            1};
    vecs[1]  = '{1'b1, 8'd9,   32'h1111_2222,  1'b1, 1'b1, 32'd0,            1};
    vecs[2]  = '{1'b1, 8'd2,   32'h3333_4444,  1'b1, 1'b1, 32'd0,            1};
    vecs[3]  = '{1'b0, 8'd200, 32'd0,          1'b1, 1'b1, 32'd0,            1};
    vecs[4]  = '{1'b0, 8'd2,   32'h0000_0010,  1'b1, 1'b0, rom_fn(16'h0010), 3};
    vecs[5]  = '{1'b1, 8'd3,   32'h0000_1234,  1'b0, 1'b0, 32'd0,            0};
    vecs[6]  = '{1'b0, 8'd3,   32'd0,          1'b1, 1'b0, 32'h0000_1234,    1};
    vecs[7]  = '{1'b0, 8'd2,   32'hABCD_FFFF,  1'b1, 1'b0, rom_fn(16'hFFFF), 3};
    vecs[8]  = '{1'b0, 8'd8,   32'd0,          1'b1, 1'b1, 32'd0,            1};
    vecs[9]  = '{1'b1, 8'd3,   32'hDEAD_BEEF,  1'b0, 1'b0, 32'd0,            0};
    vecs[10] = '{1'b0, 8'd3,   32'd0,          1'b1, 1'b0, 32'hDEAD_BEEF,    1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_ipc_in_req", 64'(ipc_in_req), 64'(0));
    chk("rst_ipc_out_valid", 64'(ipc_out_valid), 64'(0));
    chk("rst_rom_addr", 64'(rom_addr), 64'(0));
    chk("rst_value_out", 64'(value_out), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].exp_resp) exp_q.push_back({vecs[i].exp_err, vecs[i].exp_val});
      send(vecs[i].w, vecs[i].id, vecs[i].val);
      if (!vecs[i].w && vecs[i].id == 8'd2)
        chk("rom_addr", 64'(rom_addr), 64'(vecs[i].val[15:0]));
      if (vecs[i].exp_resp) begin
        wait_resp(lat);
        chk("latency", 64'(lat), 64'(vecs[i].exp_lat));
        @(posedge clk); #1;
        chk("resp_one_cycle", 64'(resp_valid), 64'(0));
        chk("value_hold", 64'(value_out), 64'(vecs[i].exp_val));
      end else begin
        repeat (2) @(posedge clk);
        #1;
      end
    end

    // IPC write forwarded to the FIFO head on the next cycle
    ipc_out_ready = 1'b1;
    fifo_exp_q.push_back({8'd5, 32'hA5A5_A5A5});
    send(1'b1, 8'd5, 32'hA5A5_A5A5);
    chk("fwd_valid", 64'(ipc_out_valid), 64'(1));
    chk("fwd_id", 64'(ipc_out_id), 64'(5));
    chk("fwd_data", 64'(ipc_out_data), 64'(32'hA5A5_A5A5));
    @(posedge clk); #1;
    chk("fwd_drained", 64'(ipc_out_valid), 64'(0));

    // Fill the FIFO; fifth write waits for a pop
    ipc_out_ready = 1'b0;
    for (int i = 0; i < WFIFO_DEPTH; i++) begin
      logic [31:0] d;
      d = $urandom();
      fifo_exp_q.push_back({8'd4, d});
      send(1'b1, 8'd4, d);
    end
    chk("full_not_ready", 64'(req_ready), 64'(0));
    fifo_exp_q.push_back({8'd4, 32'h0000_0005});
    req_valid = 1'b1; is_write = 1'b1; device_id = 8'd4; value_in = 32'h0000_0005;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("full_hold", 64'(req_ready), 64'(0));
    end
    ipc_out_ready = 1'b1;
    @(posedge clk); #1;
    ipc_out_ready = 1'b0;
    chk("ready_after_pop", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    ipc_out_ready = 1'b1;
    n = 0;
    while (ipc_out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("fill_drained", 64'(fifo_exp_q.size()), 64'(0));

    // IPC read behind two pending writes, then timeout
    ipc_out_ready = 1'b0;
    fifo_exp_q.push_back({8'd1, 32'h0101_0101});
    send(1'b1, 8'd1, 32'h0101_0101);
    fifo_exp_q.push_back({8'd1, 32'h0202_0202});
    send(1'b1, 8'd1, 32'h0202_0202);
    exp_q.push_back({1'b1, 32'd0});
    send(1'b0, 8'd6, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("drain_no_req", 64'(ipc_in_req), 64'(0));
    end
    ipc_out_ready = 1'b1;
    n = 0;
    while (!ipc_in_req && n < 20) begin
      @(posedge clk); #1; n++;
      if (ipc_in_req) chk("req_after_pops", 64'(fifo_exp_q.size()), 64'(0));
    end
    ipc_out_ready = 1'b0;
    chk("ipc_in_req_rise", 64'(ipc_in_req), 64'(1));
    chk("ipc_in_id", 64'(ipc_in_id), 64'(6));
    n = 0;
    while (ipc_in_req && n < TIMEOUT + 10) begin
      n++; @(posedge clk); #1;
    end
    chk("timeout_cycles", 64'(n), 64'(TIMEOUT));
    chk("timeout_resp", 64'(resp_valid), 64'(1));

    // IPC read answered after a few cycles
    exp_q.push_back({1'b0, 32'hCAFE_F00D});
    send(1'b0, 8'd5, 32'd0);
    wait_ipc_req();
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #1;
    ipc_in_valid = 1'b1; ipc_in_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    ipc_in_valid = 1'b0;
    chk("ipc_resp", 64'(resp_valid), 64'(1));
    chk("ipc_req_drop", 64'(ipc_in_req), 64'(0));

    // Data arriving on the final wait cycle beats the timeout
    exp_q.push_back({1'b0, 32'h600D_F00D});
    send(1'b0, 8'd1, 32'd0);
    wait_ipc_req();
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    chk("last_cycle_req", 64'(ipc_in_req), 64'(1));
    ipc_in_valid = 1'b1; ipc_in_data = 32'h600D_F00D;
    @(posedge clk); #1;
    ipc_in_valid = 1'b0;
    chk("last_cycle_resp", 64'(resp_valid), 64'(1));
    @(posedge clk); #1;

    // Reset while waiting on IPC abandons the read
    send(1'b0, 8'd7, 32'd0);
    wait_ipc_req();
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    fifo_exp_q.delete();
    @(posedge clk); #1;
    chk("rr_req_ready", 64'(req_ready), 64'(1));
    chk("rr_ipc_in_req", 64'(ipc_in_req), 64'(0));
    chk("rr_resp_valid", 64'(resp_valid), 64'(0));
    chk("rr_state", 64'(dbg_state), 64'(0));
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    exp_q.push_back({1'b0, 32'd0});
    send(1'b0, 8'd3, 32'd0);
    wait_resp(lat);
    chk("rr_console_lat", 64'(lat), 64'(1));
    @(posedge clk); #1;

    chk("resp_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("fifo_queue_empty", 64'(fifo_exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
